// File: rtl/decode_ctrl.sv
// decode_ctrl: PC sequencing, fetch issue and instruction decode
// between the fetch unit and execute.
module decode_ctrl #(
  parameter logic [13:0] RESET_PC     = 14'd1,
  parameter logic [5:0]  HALT_OPCODE  = 6'h3F,
  parameter logic [63:0] ILLEGAL_MASK = 64'h0
) (
  input  logic        clk,
  input  logic        rst_async,
  output logic        fetch_req,
  input  logic        fetch_complete,
  input  logic [15:0] inst,
  output logic [13:0] pc,
  output logic        dec_valid,
  input  logic        exec_ready,
  output logic [5:0]  opcode,
  output logic        is_long,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [7:0]  imm8,
  output logic        illegal,
  input  logic        branch_taken,
  input  logic [13:0] branch_target,
  output logic        halted
);

  typedef enum logic [2:0] {
    ISSUE,
    BUSY,
    WAIT,
    VALID,
    HALTED
  } state_t;

  state_t      state;
  logic [15:0] inst_q;
  logic [13:0] pc_inc;

  assign opcode  = inst_q[7:2];
  assign is_long = inst_q[1];
  assign rd      = inst_q[15:13];
  assign rs      = inst_q[12:10];
  assign imm8    = inst_q[15:8];
  assign illegal = ILLEGAL_MASK[opcode];
  assign pc_inc  = is_long ? 14'd2 : 14'd1;

  // fetch_req is registered, so it is high during the cycle after ISSUE;
  // the stale fetch_complete seen in that cycle is therefore ignored.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      inst_q    <= 16'h0;
      fetch_req <= 1'b0;
      dec_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      fetch_req <= 1'b0;
      case (state)
        ISSUE: begin
          fetch_req <= 1'b1;
          state     <= BUSY;
        end
        BUSY: state <= WAIT;
        WAIT: begin
          if (fetch_complete) begin
            inst_q    <= inst;
            dec_valid <= 1'b1;
            state     <= VALID;
          end
        end
        VALID: begin
          if (exec_ready) begin
            dec_valid <= 1'b0;
            if (opcode == HALT_OPCODE) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= ISSUE;
              pc    <= branch_taken ? branch_target
                                    : pc + pc_inc;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed and randomized checks of decode_ctrl
// against a transaction-level PC/field model.
module tb_decode_ctrl;

  localparam logic [63:0] MASK = 64'h0400_0000_0010_0020;

  logic        clk = 1'b0;
  logic        rst_async = 1'b1;
  logic        fetch_req;
  logic        fetch_complete = 1'b0;
  logic [15:0] inst = 16'h0;
  logic [13:0] pc;
  logic        dec_valid;
  logic        exec_ready = 1'b0;
  logic [5:0]  opcode;
  logic        is_long;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [7:0]  imm8;
  logic        illegal;
  logic        branch_taken = 1'b0;
  logic [13:0] branch_target = 14'h0;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;
  int model_pc;
  bit model_halt;

  decode_ctrl #(
    .RESET_PC(14'd1),
    .HALT_OPCODE(6'h3F),
    .ILLEGAL_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst_async(rst_async),
    .fetch_req(fetch_req),
    .fetch_complete(fetch_complete),
    .inst(inst),
    .pc(pc),
    .dec_valid(dec_valid),
    .exec_ready(exec_ready),
    .opcode(opcode),
    .is_long(is_long),
    .rd(rd),
    .rs(rs),
    .imm8(imm8),
    .illegal(illegal),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!fetch_req && n < 16) begin
      step();
      n++;
    end
    chk("fetch_req_seen", 32'(fetch_req), 1);
  endtask

  task automatic do_reset();
    rst_async      = 1'b1;
    fetch_complete = 1'b1;
    inst           = 16'h0008;
    exec_ready     = 1'b0;
    branch_taken   = 1'b0;
    step();
    step();
    chk("rst_fetch_req", 32'(fetch_req), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(pc), 1);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_is_long", 32'(is_long), 0);
    chk("rst_imm8", 32'(imm8), 0);
    chk("rst_illegal", 32'(illegal), 32'(MASK[0]));
    rst_async  = 1'b0;
    model_pc   = 1;
    model_halt = 1'b0;
    step();
    chk("first_req", 32'(fetch_req), 1);
  endtask

  task automatic run_inst(input logic [15:0] v, input int lat,
                          input int stall, input bit br,
                          input logic [13:0] tgt);
    int vi, op, lng;
    vi  = int'(v);
    op  = (vi % 256) / 4;
    lng = (vi / 2) % 2;
    wait_req();
    chk("fetch_pc", 32'(pc), 32'(model_pc));
    fetch_complete = 1'b1;
    inst           = 16'hFFFF;
    exec_ready     = 1'($urandom);
    step();
    chk("busy_no_valid", 32'(dec_valid), 0);
    chk("req_pulse", 32'(fetch_req), 0);
    for (int i = 0; i < lat; i++) begin
      fetch_complete = 1'b0;
      exec_ready     = 1'($urandom);
      step();
      chk("wait_no_valid", 32'(dec_valid), 0);
    end
    fetch_complete = 1'b1;
    inst           = v;
    exec_ready     = 1'b0;
    step();
    chk("dec_valid", 32'(dec_valid), 1);
    chk("opcode", 32'(opcode), 32'(op));
    chk("is_long", 32'(is_long), 32'(lng));
    chk("illegal", 32'(illegal), 32'((MASK >> op) & 64'd1));
    if (lng == 1) begin
      chk("rd", 32'(rd), 32'(vi / 8192));
      chk("rs", 32'(rs), 32'((vi / 1024) % 8));
      chk("imm8", 32'(imm8), 32'(vi / 256));
    end
    for (int i = 0; i < stall; i++) begin
      exec_ready     = 1'b0;
      branch_taken   = 1'b1;
      branch_target  = 14'($urandom);
      inst           = 16'($urandom);
      fetch_complete = 1'($urandom);
      step();
      chk("hold_valid", 32'(dec_valid), 1);
      chk("hold_req", 32'(fetch_req), 0);
      chk("hold_opcode", 32'(opcode), 32'(op));
      chk("hold_imm8", 32'(imm8), 32'(vi / 256));
      chk("hold_pc", 32'(pc), 32'(model_pc));
    end
    exec_ready    = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    step();
    exec_ready     = 1'($urandom);
    branch_taken   = 1'($urandom);
    branch_target  = 14'($urandom);
    fetch_complete = 1'b0;
    if (op == 63) model_halt = 1'b1;
    else if (br) model_pc = int'(tgt);
    else model_pc = (model_pc + 1 + lng) % 16384;
    chk("accept_drop", 32'(dec_valid), 0);
    chk("next_pc", 32'(pc), 32'(model_pc));
    chk("halted", 32'(halted), 32'(model_halt));
    if (!model_halt) begin
      step();
      chk("next_req", 32'(fetch_req), 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int          lat, stall;
    bit          br;

    do_reset();
    run_inst(16'h0008, 0, 0, 1'b0, 14'h0);
    run_inst(16'hA50E, 1, 0, 1'b0, 14'h0);
    run_inst(16'h0010, 0, 5, 1'b0, 14'h0);
    run_inst(16'h0004, 0, 1, 1'b1, 14'h1234);
    run_inst(16'h0000, 2, 0, 1'b1, 14'h3FFF);
    run_inst(16'h0002, 0, 0, 1'b0, 14'h0);
    run_inst(16'h0014, 0, 0, 1'b0, 14'h0);

    for (int k = 0; k < 150; k++) begin
      v = 16'($urandom);
      if (v[7:2] == 6'h3F) v[2] = 1'b0;
      lat   = int'($urandom_range(0, 3));
      stall = ($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
      br    = ($urandom % 4 == 0);
      run_inst(v, lat, stall, br, 14'($urandom));
    end

    run_inst(16'h00FC, 1, 2, 1'b1, 14'h0155);
    for (int i = 0; i < 20; i++) begin
      fetch_complete = 1'($urandom);
      exec_ready     = 1'($urandom);
      step();
      chk("halt_no_req", 32'(fetch_req), 0);
      chk("halt_no_valid", 32'(dec_valid), 0);
      chk("halt_stays", 32'(halted), 1);
    end

    do_reset();
    run_inst(16'h0006, 0, 0, 1'b0, 14'h0);
    wait_req();
    fetch_complete = 1'b0;
    step();
    step();
    #2 rst_async = 1'b1;
    #1;
    chk("midrst_pc", 32'(pc), 1);
    chk("midrst_valid", 32'(dec_valid), 0);
    chk("midrst_req", 32'(fetch_req), 0);
    step();
    chk("midrst_halted", 32'(halted), 0);
    rst_async  = 1'b0;
    model_pc   = 1;
    model_halt = 1'b0;
    step();
    chk("midrst_first_req", 32'(fetch_req), 1);
    run_inst(16'h0008, 0, 0, 1'b0, 14'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
